nodf_module_intf: RTL and testbench

- Synthesizable status monitor for one non-dataflow HLS block using the ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_continue).
- One instance per monitored sub-module in the simulation monitor layer.
- Tracks transaction state, counts starts, readys and dones, and measures per-transaction latency in cycles.
- Freezes all statistics when the global finish flag is raised, so a dumper can read them.

---
 rtl/nodf_module_intf.sv | 160 ++++++++++++++++
 tb/tb_nodf_module_intf.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nodf_module_intf.sv
// Status monitor for one ap_ctrl_hs block: tracks the transaction state, counts
// starts/readys/dones and measures per-transaction latency; everything freezes on finish.
module nodf_module_intf #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] ready_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] min_lat,
    output logic [LAT_W-1:0] max_lat,
    output logic             lat_valid,
    output logic             err_done_idle,
    output logic             finished
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_CONT = 2'd2
    } state_e;

    localparam int EW = ((CNT_W > LAT_W) ? CNT_W : LAT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_ONES = '1;
    localparam logic [LAT_W-1:0] LAT_ONES = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
    logic [CNT_W-1:0] ready_cnt_q, ready_cnt_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [LAT_W-1:0] start_cycle_q, start_cycle_d;
    logic [LAT_W-1:0] last_lat_q, last_lat_d;
    logic [LAT_W-1:0] min_lat_q, min_lat_d;
    logic [LAT_W-1:0] max_lat_q, max_lat_d;
    logic             lat_valid_q, lat_valid_d;
    logic             err_done_idle_q, err_done_idle_d;
    logic             finished_q, finished_d;

    logic             frozen;
    logic             complete;
    logic [LAT_W-1:0] start_ref;
    logic [EW-1:0]    lat_wide;
    logic [LAT_W-1:0] lat_sat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_ONES) ? v : v + CNT_W'(1);
    endfunction

    // A start and done in the same IDLE cycle measure from the current cycle, giving latency 1.
    assign start_ref = (state_q == ST_IDLE) ? LAT_W'(cycle_cnt_q) : start_cycle_q;
    assign lat_wide  = EW'(cycle_cnt_q) - EW'(start_ref) + EW'(1);
    assign lat_sat   = (lat_wide > EW'(LAT_ONES)) ? LAT_ONES : lat_wide[LAT_W-1:0];
    assign frozen    = finish | finished_q;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d         = state_q;
        cycle_cnt_d     = cycle_cnt_q;
        start_cnt_d     = start_cnt_q;
        ready_cnt_d     = ready_cnt_q;
        done_cnt_d      = done_cnt_q;
        start_cycle_d   = start_cycle_q;
        last_lat_d      = last_lat_q;
        min_lat_d       = min_lat_q;
        max_lat_d       = max_lat_q;
        lat_valid_d     = lat_valid_q;
        err_done_idle_d = err_done_idle_q;
        finished_d      = finished_q | finish;
        complete        = 1'b0;

        if (!frozen) begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
            if (ap_ready) ready_cnt_d = sat_inc(ready_cnt_q);

            unique case (state_q)
                ST_IDLE: begin
                    if (ap_start) begin
                        start_cnt_d   = sat_inc(start_cnt_q);
                        start_cycle_d = LAT_W'(cycle_cnt_q);
                        if (ap_done) complete = 1'b1;
                        else         state_d  = ST_RUN;
                    end else if (ap_done) begin
                        err_done_idle_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ap_done) complete = 1'b1;
                end
                ST_WAIT_CONT: begin
                    if (ap_continue) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (complete) begin
                done_cnt_d  = sat_inc(done_cnt_q);
                last_lat_d  = lat_sat;
                min_lat_d   = (lat_sat < min_lat_q) ? lat_sat : min_lat_q;
                max_lat_d   = (lat_sat > max_lat_q) ? lat_sat : max_lat_q;
                lat_valid_d = 1'b1;
                state_d     = ap_continue ? ST_IDLE : ST_WAIT_CONT;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
        if (reset) begin
            state_q         <= ST_IDLE;
            cycle_cnt_q     <= '0;
            start_cnt_q     <= '0;
            ready_cnt_q     <= '0;
            done_cnt_q      <= '0;
            start_cycle_q   <= '0;
            last_lat_q      <= '0;
            min_lat_q       <= LAT_ONES;
            max_lat_q       <= '0;
            lat_valid_q     <= 1'b0;
            err_done_idle_q <= 1'b0;
            finished_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cycle_cnt_q     <= cycle_cnt_d;
            start_cnt_q     <= start_cnt_d;
            ready_cnt_q     <= ready_cnt_d;
            done_cnt_q      <= done_cnt_d;
            start_cycle_q   <= start_cycle_d;
            last_lat_q      <= last_lat_d;
            min_lat_q       <= min_lat_d;
            max_lat_q       <= max_lat_d;
            lat_valid_q     <= lat_valid_d;
            err_done_idle_q <= err_done_idle_d;
            finished_q      <= finished_d;
        end
    end

    assign state         = state_q;
    assign cycle_cnt     = cycle_cnt_q;
    assign start_cnt     = start_cnt_q;
    assign ready_cnt     = ready_cnt_q;
    assign done_cnt      = done_cnt_q;
    assign last_lat      = last_lat_q;
    assign min_lat       = min_lat_q;
    assign max_lat       = max_lat_q;
    assign lat_valid     = lat_valid_q;
    assign err_done_idle = err_done_idle_q;
    assign finished      = finished_q;

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed bench for nodf_module_intf: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_nodf_module_intf;

    logic        clock;
    logic        reset;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_continue;
    logic        finish;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] start_cnt;
    logic [31:0] ready_cnt;
    logic [31:0] done_cnt;
    logic [31:0] last_lat;
    logic [31:0] min_lat;
    logic [31:0] max_lat;
    logic        lat_valid;
    logic        err_done_idle;
    logic        finished;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    nodf_module_intf dut (
        .clock         (clock),
        .reset         (reset),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_continue   (ap_continue),
        .finish        (finish),
        .state         (state),
        .cycle_cnt     (cycle_cnt),
        .start_cnt     (start_cnt),
        .ready_cnt     (ready_cnt),
        .done_cnt      (done_cnt),
        .last_lat      (last_lat),
        .min_lat       (min_lat),
        .max_lat       (max_lat),
        .lat_valid     (lat_valid),
        .err_done_idle (err_done_idle),
        .finished      (finished)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Transaction of lat >= 2 edges: start edge, lat-2 idle edges, done edge.
    task automatic run_txn(input int lat);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (lat - 2) tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        ap_start    = 1'b0;
        ap_ready    = 1'b0;
        ap_done     = 1'b0;
        ap_continue = 1'b1;
        finish      = 1'b0;

        // Reset then idle
        repeat (3) tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_min", 64'(min_lat), 64'(ONES));
        reset = 1'b0;
        repeat (5) tick();
        check("idle_cycle", 64'(cycle_cnt), 64'd5);
        check("idle_start", 64'(start_cnt), 64'd0);
        check("idle_ready", 64'(ready_cnt), 64'd0);
        check("idle_done", 64'(done_cnt), 64'd0);
        check("idle_min", 64'(min_lat), 64'(ONES));
        check("idle_max", 64'(max_lat), 64'd0);
        check("idle_valid", 64'(lat_valid), 64'd0);
        check("idle_fin", 64'(finished), 64'd0);

        // Single transaction of latency 5 with one ready pulse
        ap_start = 1'b1;
        ap_ready = 1'b1;
        tick();
        ap_start = 1'b0;
        ap_ready = 1'b0;
        check("t1_state_run", 64'(state), 64'd1);
        check("t1_start", 64'(start_cnt), 64'd1);
        repeat (3) tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t1_done", 64'(done_cnt), 64'd1);
        check("t1_ready", 64'(ready_cnt), 64'd1);
        check("t1_last", 64'(last_lat), 64'd5);
        check("t1_min", 64'(min_lat), 64'd5);
        check("t1_max", 64'(max_lat), 64'd5);
        check("t1_valid", 64'(lat_valid), 64'd1);
        check("t1_state_idle", 64'(state), 64'd0);

        // Latencies 3 then 7
        run_txn(3);
        run_txn(7);
        check("t2_done", 64'(done_cnt), 64'd3);
        check("t2_start", 64'(start_cnt), 64'd3);
        check("t2_last", 64'(last_lat), 64'd7);
        check("t2_min", 64'(min_lat), 64'd3);
        check("t2_max", 64'(max_lat), 64'd7);

        // Start and done together: latency 1
        ap_start = 1'b1;
        ap_done  = 1'b1;
        tick();
        ap_start = 1'b0;
        ap_done  = 1'b0;
        check("t3_last", 64'(last_lat), 64'd1);
        check("t3_min", 64'(min_lat), 64'd1);
        check("t3_done", 64'(done_cnt), 64'd4);
        check("t3_start", 64'(start_cnt), 64'd4);
        check("t3_state", 64'(state), 64'd0);

        // Completion with continue low parks in WAIT_CONT
        ap_continue = 1'b0;
        run_txn(3);
        check("t4_state_w0", 64'(state), 64'd2);
        check("t4_done", 64'(done_cnt), 64'd5);
        tick();
        check("t4_state_w1", 64'(state), 64'd2);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t4_state_w2", 64'(state), 64'd2);
        check("t4_done_hold", 64'(done_cnt), 64'd5);
        tick();
        check("t4_state_w3", 64'(state), 64'd2);
        ap_continue = 1'b1;
        tick();
        check("t4_state_idle", 64'(state), 64'd0);
        check("t4_err", 64'(err_done_idle), 64'd0);
        check("t4_last", 64'(last_lat), 64'd3);

        // Back-to-back: start held through completion
        ap_start = 1'b1;
        tick();
        check("t5_start_a", 64'(start_cnt), 64'd6);
        tick();
        check("t5_no_recount", 64'(start_cnt), 64'd6);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t5_idle", 64'(state), 64'd0);
        check("t5_done_a", 64'(done_cnt), 64'd6);
        tick();
        ap_start = 1'b0;
        check("t5_start_b", 64'(start_cnt), 64'd7);
        check("t5_run_b", 64'(state), 64'd1);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t5_done_b", 64'(done_cnt), 64'd7);
        check("t5_last_b", 64'(last_lat), 64'd2);
        check("t5_max", 64'(max_lat), 64'd7);

        // Reset mid-transaction, coincident done is not recorded
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        reset   = 1'b1;
        ap_done = 1'b1;
        tick();
        reset   = 1'b0;
        ap_done = 1'b0;
        check("t6_state", 64'(state), 64'd0);
        check("t6_cycle", 64'(cycle_cnt), 64'd0);
        check("t6_done", 64'(done_cnt), 64'd0);
        check("t6_valid", 64'(lat_valid), 64'd0);
        check("t6_min", 64'(min_lat), 64'(ONES));
        check("t6_last", 64'(last_lat), 64'd0);

        // Start tied low: readys counted, stray done flags an error
        for (int i = 0; i < 3; i++) begin
            ap_ready = 1'b1;
            tick();
            ap_ready = 1'b0;
            tick();
        end
        check("t7_ready", 64'(ready_cnt), 64'd3);
        check("t7_err_pre", 64'(err_done_idle), 64'd0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        check("t7_err", 64'(err_done_idle), 64'd1);
        check("t7_done", 64'(done_cnt), 64'd0);
        check("t7_start", 64'(start_cnt), 64'd0);
        check("t7_state", 64'(state), 64'd0);

        // Finish freezes statistics mid-transaction
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t8_err_clr", 64'(err_done_idle), 64'd0);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (8) tick();
        check("t8_cycle_pre", 64'(cycle_cnt), 64'd9);
        finish   = 1'b1;
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        ap_start = 1'b1;
        tick();
        finish = 1'b0;
        check("t8_finished", 64'(finished), 64'd1);
        check("t8_cycle", 64'(cycle_cnt), 64'd9);
        check("t8_state", 64'(state), 64'd1);
        check("t8_done", 64'(done_cnt), 64'd0);
        check("t8_ready", 64'(ready_cnt), 64'd0);
        check("t8_start", 64'(start_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            ap_start = i[0];
            ap_done  = ~i[0];
            ap_ready = ~ap_ready;
            tick();
        end
        ap_start = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        check("t8_cycle_hold", 64'(cycle_cnt), 64'd9);
        check("t8_done_hold", 64'(done_cnt), 64'd0);
        check("t8_ready_hold", 64'(ready_cnt), 64'd0);
        check("t8_valid_hold", 64'(lat_valid), 64'd0);
        check("t8_fin_hold", 64'(finished), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t8_fin_clr", 64'(finished), 64'd0);
        check("t8_cycle_clr", 64'(cycle_cnt), 64'd0);
        check("t8_start_clr", 64'(start_cnt), 64'd0);
        check("t8_state_clr", 64'(state), 64'd0);
        tick();
        check("t8_cycle_run", 64'(cycle_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
